// File: rtl/gpr_wb_ctrl.sv
// Register-file write-back controller: merges a priority ALU path with a FIFO-buffered LSU path.
// Optional macro WB_BYPASS_EN lets an LSU result skip an empty FIFO when the ALU is idle.
module gpr_wb_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_wr_en_i,
  input  logic [ADDR_WIDTH-1:0]         alu_wr_addr_i,
  input  logic [DATA_WIDTH-1:0]         alu_wr_data_i,
  input  logic                          lsu_valid_i,
  output logic                          lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0]         lsu_wr_addr_i,
  input  logic [DATA_WIDTH-1:0]         lsu_wr_data_i,
  output logic                          wr_en_o,
  output logic [ADDR_WIDTH-1:0]         wr_addr_o,
  output logic [DATA_WIDTH-1:0]         wr_data_o,
  output logic [2**ADDR_WIDTH-1:0]      busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] Full = CW'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] live_q;
  logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  logic alu_valid, empty, xfer, lsu_nz, bypass;
  logic pop_kill, pop_live, pop, push, push_live;

  assign alu_valid   = alu_wr_en_i && (alu_wr_addr_i != '0);
  assign empty       = (cnt_q == '0);
  assign lsu_ready_o = !rst && (cnt_q < Full);
  assign xfer        = lsu_valid_i && lsu_ready_o;
  assign lsu_nz      = (lsu_wr_addr_i != '0);

`ifdef WB_BYPASS_EN
  assign bypass = empty && !alu_valid && xfer && lsu_nz;
`else
  assign bypass = 1'b0;
`endif

  // Killed heads drain even under ALU traffic; live heads wait for an idle ALU slot.
  assign pop_kill  = !empty && !live_q[rd_ptr_q];
  assign pop_live  = !empty && live_q[rd_ptr_q] && !alu_valid;
  assign pop       = pop_kill || pop_live;
  assign push      = xfer && lsu_nz && !bypass;
  // The ALU write is younger, so a same-cycle LSU write to the same register is dead on arrival.
  assign push_live = !(alu_valid && (alu_wr_addr_i == lsu_wr_addr_i));

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      live_q    <= '0;
    end else begin
      wr_en_q <= alu_valid || pop_live || bypass;
      if (alu_valid) begin
        wr_addr_q <= alu_wr_addr_i;
        wr_data_q <= alu_wr_data_i;
      end else if (pop_live) begin
        wr_addr_q <= addr_q[rd_ptr_q];
        wr_data_q <= data_q[rd_ptr_q];
      end else if (bypass) begin
        wr_addr_q <= lsu_wr_addr_i;
        wr_data_q <= lsu_wr_data_i;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (alu_valid && (addr_q[i] == alu_wr_addr_i)) live_q[i] <= 1'b0;
      end
      if (pop) begin
        live_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q         <= rd_ptr_q + PW'(1);
      end
      if (push) begin
        live_q[wr_ptr_q] <= push_live;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by live_q and cnt_q.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= lsu_wr_addr_i;
      data_q[wr_ptr_q] <= lsu_wr_data_i;
    end
  end

  always_comb begin
    busy_o = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (live_q[i]) busy_o[addr_q[i]] = 1'b1;
    end
  end

  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign fifo_cnt_o = cnt_q;

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Directed bench for gpr_wb_ctrl; expected writes go through a scoreboard queue.
module tb_gpr_wb_ctrl;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_wr_en_i = 1'b0;
  logic [4:0]  alu_wr_addr_i = '0;
  logic [31:0] alu_wr_data_i = '0;
  logic        lsu_valid_i = 1'b0;
  logic        lsu_ready_o;
  logic [4:0]  lsu_wr_addr_i = '0;
  logic [31:0] lsu_wr_data_i = '0;
  logic        wr_en_o;
  logic [4:0]  wr_addr_o;
  logic [31:0] wr_data_o;
  logic [31:0] busy_o;
  logic [2:0]  fifo_cnt_o;

  int checks = 0;
  int errors = 0;
  wr_t exp_q[$];

  gpr_wb_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .alu_wr_en_i   (alu_wr_en_i),
    .alu_wr_addr_i (alu_wr_addr_i),
    .alu_wr_data_i (alu_wr_data_i),
    .lsu_valid_i   (lsu_valid_i),
    .lsu_ready_o   (lsu_ready_o),
    .lsu_wr_addr_i (lsu_wr_addr_i),
    .lsu_wr_data_i (lsu_wr_data_i),
    .wr_en_o       (wr_en_o),
    .wr_addr_o     (wr_addr_o),
    .wr_data_o     (wr_data_o),
    .busy_o        (busy_o),
    .fifo_cnt_o    (fifo_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ae, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    alu_wr_en_i   = ae;
    alu_wr_addr_i = aa;
    alu_wr_data_i = ad;
    lsu_valid_i   = lv;
    lsu_wr_addr_i = la;
    lsu_wr_data_i = ld;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Every issued write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wr_en_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {27'd0, wr_addr_o, wr_data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(wr_addr_o), 64'(e.a));
        chk("wr_data", 64'(wr_data_o), 64'(e.d));
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic [31:0] exp_busy;
    logic [4:0]  la;

    // Reset state
    idle();
    tick();
    tick();
    chk("rst_wr_en", 64'(wr_en_o), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr_o), 64'd0);
    chk("rst_wr_data", 64'(wr_data_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_cnt", 64'(fifo_cnt_o), 64'd0);
    chk("rst_ready", 64'(lsu_ready_o), 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(lsu_ready_o), 64'd1);

    // ALU only, then address 0 ignored
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    exp_q.push_back('{a: 5'd5, d: 32'h1234});
    tick();
    chk("alu_wr_en", 64'(wr_en_o), 64'd1);
    chk("alu_wr_addr", 64'(wr_addr_o), 64'd5);
    chk("alu_wr_data", 64'(wr_data_o), 64'h1234);
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    tick();
    chk("alu_addr0", 64'(wr_en_o), 64'd0);

    // Latency, FIFO empty and ALU idle
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA5);
    exp_q.push_back('{a: 5'd7, d: 32'hA5});
    tick();
    idle();
`ifdef WB_BYPASS_EN
    chk("lat_n1_wr_en", 64'(wr_en_o), 64'd1);
    chk("lat_n1_cnt", 64'(fifo_cnt_o), 64'd0);
    chk("lat_n1_busy", 64'(busy_o), 64'd0);
    tick();
    chk("lat_n2_wr_en", 64'(wr_en_o), 64'd0);
`else
    chk("lat_n1_wr_en", 64'(wr_en_o), 64'd0);
    chk("lat_n1_cnt", 64'(fifo_cnt_o), 64'd1);
    chk("lat_n1_busy", 64'(busy_o), 64'h80);
    tick();
    chk("lat_n2_wr_en", 64'(wr_en_o), 64'd1);
    chk("lat_n2_cnt", 64'(fifo_cnt_o), 64'd0);
    chk("lat_n2_busy", 64'(busy_o), 64'd0);
`endif

    // Fill under continuous ALU writes
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 5'(10 + k), 32'h100 + 32'(k), 1'b1, 5'(20 + k), 32'h200 + 32'(k));
      exp_q.push_back('{a: 5'(10 + k), d: 32'h100 + 32'(k)});
      chk("fill_ready", 64'(lsu_ready_o), (k < 4) ? 64'd1 : 64'd0);
      tick();
    end
    idle();
    chk("fill_cnt", 64'(fifo_cnt_o), 64'd4);
    chk("fill_busy", 64'(busy_o), 64'h00F0_0000);
    for (int k = 0; k < 4; k++) exp_q.push_back('{a: 5'(20 + k), d: 32'h200 + 32'(k)});
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("drain_wr_en", 64'(wr_en_o), 64'd1);
    end
    chk("drain_cnt", 64'(fifo_cnt_o), 64'd0);
    tick();
    chk("drain_done", 64'(wr_en_o), 64'd0);

    // WAW kill of a buffered entry
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd3, 32'h33);
    exp_q.push_back('{a: 5'd1, d: 32'h11});
    tick();
    chk("waw_busy_set", 64'(busy_o), 64'h8);
    drive(1'b1, 5'd3, 32'h3A, 1'b0, 5'd0, 32'd0);
    exp_q.push_back('{a: 5'd3, d: 32'h3A});
    tick();
    idle();
    chk("waw_busy_clr", 64'(busy_o), 64'd0);
    chk("waw_cnt_killed", 64'(fifo_cnt_o), 64'd1);
    chk("waw_alu_addr", 64'(wr_addr_o), 64'd3);
    tick();
    chk("waw_kill_pop", 64'(fifo_cnt_o), 64'd0);
    tick();
    chk("waw_no_write", 64'(wr_en_o), 64'd0);

    // Same-cycle ALU and LSU to register 9
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'h77);
    exp_q.push_back('{a: 5'd9, d: 32'h99});
    tick();
    idle();
    chk("same_wr_data", 64'(wr_data_o), 64'h99);
    chk("same_busy", 64'(busy_o), 64'd0);
    tick();
    chk("same_no_write", 64'(wr_en_o), 64'd0);
    chk("same_cnt", 64'(fifo_cnt_o), 64'd0);

    // Wrap-around: ten enqueue/pop pairs, ALU active on odd iterations
    for (int i = 0; i < 10; i++) begin
      d  = $urandom;
      la = 5'(24 + (i % 8));
      drive((i % 2) == 1, 5'd2, 32'hA000 + 32'(i), 1'b1, la, d);
      if ((i % 2) == 1) exp_q.push_back('{a: 5'd2, d: 32'hA000 + 32'(i)});
      exp_q.push_back('{a: la, d: d});
      tick();
      idle();
      exp_busy = 32'd1 << la;
`ifdef WB_BYPASS_EN
      if ((i % 2) == 0) exp_busy = 32'd0;
`endif
      chk("wrap_busy_live", 64'(busy_o), 64'(exp_busy));
      tick();
      chk("wrap_busy_clr", 64'(busy_o), 64'd0);
    end
    tick();

    // Reset with three buffered entries
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd2, 32'hB0 + 32'(k), 1'b1, 5'(24 + k), 32'hC0 + 32'(k));
      exp_q.push_back('{a: 5'd2, d: 32'hB0 + 32'(k)});
      tick();
    end
    idle();
    chk("pre_rst_cnt", 64'(fifo_cnt_o), 64'd3);
    rst = 1'b1;
    #1;
    chk("rst_ready_low", 64'(lsu_ready_o), 64'd0);
    tick();
    rst = 1'b0;
    chk("midrst_cnt", 64'(fifo_cnt_o), 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_wr_en", 64'(wr_en_o), 64'd0);
    for (int k = 0; k < 6; k++) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
